usb_fs_in_rr_arb: RTL and testbench

- Round-robin arbiter and data-path scheduler for the shared IN packet path of the full-speed protocol engine.
- Sits between N IN-endpoint clients (control EP, serial bridge EP, NAK stub, future EPs) and the single IN-PE buffer write port.
- Grants one requester at a time and muxes its put/data/done onto the PE.
- Holds a grant stable while the PE is transmitting; optionally revokes a stalled holder.

---
 rtl/usb_fs_pkg.sv | 25 ++
 rtl/usb_fs_in_rr_arb_if.sv | 28 ++
 rtl/usb_rr_pick.sv | 32 +++
 rtl/usb_fs_in_rr_arb.sv | 146 ++++++++++++++
 tb/tb_usb_fs_in_rr_arb.sv | 342 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/usb_fs_pkg.sv
// Shared types and constants for the full-speed IN path arbiter.
package usb_fs_pkg;

    localparam int unsigned USB_BYTE_W       = 8;
    localparam int unsigned ARB_MAX_HOLD_DEF = 4096;
    localparam int unsigned ARB_HOLD_W_DEF   = 13;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_GRANT = 2'd1,
        ARB_GAP   = 2'd2
    } arb_state_e;

    typedef struct packed {
        logic                  put;
        logic [USB_BYTE_W-1:0] data;
        logic                  done;
    } in_beat_t;

    // Index width that stays legal for a single requester.
    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/usb_fs_in_rr_arb_if.sv
// EP-side and PE-side signals of the shared IN packet path.
interface usb_fs_in_rr_arb_if #(
    parameter int unsigned NUM_IN_EPS = 3
);
    import usb_fs_pkg::*;

    logic [NUM_IN_EPS-1:0]            in_ep_req;
    logic [NUM_IN_EPS-1:0]            in_ep_grant;
    logic [NUM_IN_EPS-1:0]            in_ep_data_put;
    logic [USB_BYTE_W*NUM_IN_EPS-1:0] in_ep_data;
    logic [NUM_IN_EPS-1:0]            in_ep_data_done;
    logic                             pe_busy;
    logic                             arb_data_put;
    logic [USB_BYTE_W-1:0]            arb_data;
    logic                             arb_data_done;
    logic                             arb_timeout;

    modport master (
        output in_ep_req, in_ep_data_put, in_ep_data, in_ep_data_done, pe_busy,
        input  in_ep_grant, arb_data_put, arb_data, arb_data_done, arb_timeout
    );

    modport slave (
        input  in_ep_req, in_ep_data_put, in_ep_data, in_ep_data_done, pe_busy,
        output in_ep_grant, arb_data_put, arb_data, arb_data_done, arb_timeout
    );

endinterface

// File: rtl/usb_rr_pick.sv
// Combinational rotating-priority picker: first request after last_idx, with wrap.
module usb_rr_pick
    import usb_fs_pkg::*;
#(
    parameter  int unsigned N  = 3,
    localparam int unsigned IW = idx_w(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last_idx,
    output logic [N-1:0]  pick_oh_c,
    output logic [IW-1:0] pick_idx_c,
    output logic          pick_any_c
);

    logic [IW-1:0] cand;

    always_comb begin
        pick_oh_c  = '0;
        pick_idx_c = '0;
        pick_any_c = 1'b0;
        cand       = '0;
        for (int unsigned k = 1; k <= N; k++) begin
            cand = IW'((32'(last_idx) + k) % N);
            if (!pick_any_c && req[cand]) begin
                pick_any_c      = 1'b1;
                pick_oh_c[cand] = 1'b1;
                pick_idx_c      = cand;
            end
        end
    end

endmodule

// File: rtl/usb_fs_in_rr_arb.sv
// Round-robin arbiter/mux for the shared IN-PE buffer write port.
// Optional holder revocation: define USB_IN_ARB_HOLD_TIMEOUT_EN.
module usb_fs_in_rr_arb
    import usb_fs_pkg::*;
#(
    parameter int unsigned NUM_IN_EPS = 3,
    parameter int unsigned MAX_HOLD   = ARB_MAX_HOLD_DEF,
    parameter int unsigned HOLD_W     = ARB_HOLD_W_DEF
) (
    input logic               clk,
    input logic               reset_n,
    usb_fs_in_rr_arb_if.slave bus
);

    localparam int unsigned IW = idx_w(NUM_IN_EPS);
    localparam int unsigned BW = USB_BYTE_W;

    if (NUM_IN_EPS < 1 || NUM_IN_EPS > 16 || (64'd1 << HOLD_W) <= 64'(MAX_HOLD)) begin : g_bad_cfg
        $error("usb_fs_in_rr_arb: illegal NUM_IN_EPS / HOLD_W / MAX_HOLD");
    end

    arb_state_e            state_q, state_d;
    logic [NUM_IN_EPS-1:0] grant_q, grant_d;
    logic [IW-1:0]         last_idx_q, last_idx_d;
    logic [IW-1:0]         holder_q, holder_d;
    logic [NUM_IN_EPS-1:0] eligible_c;
    logic [NUM_IN_EPS-1:0] pick_oh_c;
    logic [IW-1:0]         pick_idx_c;
    logic                  pick_any_c;
    logic                  holder_req_c;
    logic                  revoke_c;
    in_beat_t              beat_c;

    assign holder_req_c = |(bus.in_ep_req & grant_q);

`ifdef USB_IN_ARB_HOLD_TIMEOUT_EN
    logic [HOLD_W-1:0]     hold_q, hold_d;
    logic [NUM_IN_EPS-1:0] lockout_q, lockout_d;
    logic                  timeout_q, timeout_d;

    assign eligible_c = bus.in_ep_req & ~lockout_q;
    assign revoke_c   = (state_q == ARB_GRANT) && holder_req_c && !bus.pe_busy &&
                        !beat_c.put && (hold_q == HOLD_W'(MAX_HOLD));

    // Idle-hold counter and lockout of revoked holders until they drop req.
    always_comb begin
        hold_d    = hold_q + HOLD_W'(1);
        timeout_d = 1'b0;
        lockout_d = lockout_q & bus.in_ep_req;
        if (state_q != ARB_GRANT || bus.pe_busy || beat_c.put) begin
            hold_d = '0;
        end
        if (revoke_c) begin
            hold_d    = '0;
            timeout_d = 1'b1;
            lockout_d = lockout_d | grant_q;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hold_q    <= '0;
            lockout_q <= '0;
            timeout_q <= 1'b0;
        end else begin
            hold_q    <= hold_d;
            lockout_q <= lockout_d;
            timeout_q <= timeout_d;
        end
    end

    assign bus.arb_timeout = timeout_q;
`else
    assign eligible_c      = bus.in_ep_req;
    assign revoke_c        = 1'b0;
    assign bus.arb_timeout = 1'b0;
`endif

    usb_rr_pick #(.N(NUM_IN_EPS)) u_pick (
        .req        (eligible_c),
        .last_idx   (last_idx_q),
        .pick_oh_c  (pick_oh_c),
        .pick_idx_c (pick_idx_c),
        .pick_any_c (pick_any_c)
    );

    // GAP arbitrates like IDLE so back-to-back holders see exactly one empty cycle.
    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        last_idx_d = last_idx_q;
        holder_d   = holder_q;
        unique case (state_q)
            ARB_IDLE, ARB_GAP: begin
                grant_d = '0;
                state_d = ARB_IDLE;
                if (!bus.pe_busy && pick_any_c) begin
                    grant_d  = pick_oh_c;
                    holder_d = pick_idx_c;
                    state_d  = ARB_GRANT;
                end
            end
            ARB_GRANT: begin
                if ((!holder_req_c && !bus.pe_busy) || revoke_c) begin
                    grant_d    = '0;
                    last_idx_d = holder_q;
                    state_d    = ARB_GAP;
                end
            end
            default: begin
                grant_d = '0;
                state_d = ARB_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ARB_IDLE;
            grant_q    <= '0;
            last_idx_q <= IW'(NUM_IN_EPS - 1);
            holder_q   <= '0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            last_idx_q <= last_idx_d;
            holder_q   <= holder_d;
        end
    end

    // Registered grant gates the mux; non-holders are dropped, never buffered.
    always_comb begin
        beat_c      = '0;
        beat_c.put  = |(bus.in_ep_data_put & grant_q);
        beat_c.done = |(bus.in_ep_data_done & grant_q);
        if (|grant_q) begin
            beat_c.data = bus.in_ep_data[BW*holder_q +: BW];
        end
    end

    assign bus.in_ep_grant   = grant_q;
    assign bus.arb_data_put  = beat_c.put;
    assign bus.arb_data      = beat_c.data;
    assign bus.arb_data_done = beat_c.done;

endmodule

// File: tb/tb_usb_fs_in_rr_arb.sv
// Directed bench for usb_fs_in_rr_arb (NUM_IN_EPS=3); honours USB_IN_ARB_HOLD_TIMEOUT_EN.
module tb_usb_fs_in_rr_arb;
    import usb_fs_pkg::*;

    localparam int unsigned N = 3;
`ifdef USB_IN_ARB_HOLD_TIMEOUT_EN
    localparam int unsigned TB_MAX_HOLD = 16;
`else
    localparam int unsigned TB_MAX_HOLD = ARB_MAX_HOLD_DEF;
`endif

    logic clk = 1'b0;
    logic reset_n;
    int   n_cmp = 0;
    int   n_err = 0;

    usb_fs_in_rr_arb_if #(.NUM_IN_EPS(N)) bus_if ();

    usb_fs_in_rr_arb #(
        .NUM_IN_EPS (N),
        .MAX_HOLD   (TB_MAX_HOLD),
        .HOLD_W     (13)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus_if)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset_n                = 1'b0;
        bus_if.in_ep_req       = '0;
        bus_if.in_ep_data_put  = '0;
        bus_if.in_ep_data      = '0;
        bus_if.in_ep_data_done = '0;
        bus_if.pe_busy         = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++;
        if (bus_if.in_ep_grant !== 3'b000) begin
            n_err++; $display("FAIL reset_grant: got %b expected 000", bus_if.in_ep_grant);
        end
        n_cmp++;
        if (bus_if.arb_timeout !== 1'b0) begin
            n_err++; $display("FAIL reset_timeout: got %b expected 0", bus_if.arb_timeout);
        end
        n_cmp++;
        if ({bus_if.arb_data_put, bus_if.arb_data, bus_if.arb_data_done} !== 10'h000) begin
            n_err++; $display("FAIL reset_mux: got %b/%h/%b expected 0/00/0",
                              bus_if.arb_data_put, bus_if.arb_data, bus_if.arb_data_done);
        end
        reset_n = 1'b1;
        tick();
        @(negedge clk);
        n_cmp++;
        if (bus_if.in_ep_grant !== 3'b000) begin
            n_err++; $display("FAIL reset_noreq_grant: got %b expected 000", bus_if.in_ep_grant);
        end
    endtask

    task automatic test_round_robin();
        logic [2:0] exp_oh;
        tick();
        bus_if.in_ep_req = 3'b111;
        for (int h = 0; h < 6; h++) begin
            exp_oh = 3'b001 << (h % 3);
            tick();
            @(negedge clk);
            n_cmp++;
            if (bus_if.in_ep_grant !== exp_oh) begin
                n_err++; $display("FAIL rr_grant[%0d]: got %b expected %b", h, bus_if.in_ep_grant, exp_oh);
            end
            repeat (3) tick();
            bus_if.in_ep_req = bus_if.in_ep_req & ~exp_oh;
            tick();
            @(negedge clk);
            n_cmp++;
            if (bus_if.in_ep_grant !== 3'b000) begin
                n_err++; $display("FAIL rr_gap[%0d]: got %b expected 000", h, bus_if.in_ep_grant);
            end
            bus_if.in_ep_req = bus_if.in_ep_req | exp_oh;
        end
        bus_if.in_ep_req = '0;
    endtask

    task automatic test_single();
        tick();
        bus_if.in_ep_req = 3'b010;
        @(negedge clk);
        n_cmp++;
        if (bus_if.in_ep_grant !== 3'b000) begin
            n_err++; $display("FAIL single_latency: got %b expected 000", bus_if.in_ep_grant);
        end
        tick();
        bus_if.in_ep_data_put = 3'b010;
        bus_if.in_ep_data     = 24'h00A500;
        @(negedge clk);
        n_cmp++;
        if (bus_if.in_ep_grant !== 3'b010) begin
            n_err++; $display("FAIL single_grant: got %b expected 010", bus_if.in_ep_grant);
        end
        n_cmp++;
        if ({bus_if.arb_data_put, bus_if.arb_data} !== {1'b1, 8'hA5}) begin
            n_err++; $display("FAIL single_put: got %b/%h expected 1/a5", bus_if.arb_data_put, bus_if.arb_data);
        end
        tick();
        bus_if.in_ep_data_put  = 3'b000;
        bus_if.in_ep_data_done = 3'b010;
        @(negedge clk);
        n_cmp++;
        if ({bus_if.arb_data_put, bus_if.arb_data_done} !== 2'b01) begin
            n_err++; $display("FAIL single_done: got put=%b done=%b expected 0/1",
                              bus_if.arb_data_put, bus_if.arb_data_done);
        end
        tick();
        bus_if.in_ep_data_done = 3'b000;
        bus_if.in_ep_req       = 3'b000;
        @(negedge clk);
        n_cmp++;
        if (bus_if.in_ep_grant !== 3'b010) begin
            n_err++; $display("FAIL single_hold: got %b expected 010", bus_if.in_ep_grant);
        end
        tick();
        @(negedge clk);
        n_cmp++;
        if ({bus_if.in_ep_grant, bus_if.arb_data} !== 11'h000) begin
            n_err++; $display("FAIL single_gap: got %b/%h expected 000/00", bus_if.in_ep_grant, bus_if.arb_data);
        end
        tick();
        bus_if.in_ep_data = '0;
    endtask

    task automatic test_pe_busy();
        int held;
        bus_if.in_ep_req = 3'b001;
        tick();
        @(negedge clk);
        n_cmp++;
        if (bus_if.in_ep_grant !== 3'b001) begin
            n_err++; $display("FAIL busy_grant: got %b expected 001", bus_if.in_ep_grant);
        end
        tick();
        bus_if.in_ep_req = 3'b000;
        bus_if.pe_busy   = 1'b1;
        held = 0;
        repeat (20) begin
            tick();
            @(negedge clk);
            if (bus_if.in_ep_grant === 3'b001) held++;
        end
        n_cmp++;
        if (held !== 20) begin
            n_err++; $display("FAIL busy_held_cycles: got %0d expected 20", held);
        end
        bus_if.pe_busy = 1'b0;
        tick();
        @(negedge clk);
        n_cmp++;
        if (bus_if.in_ep_grant !== 3'b000) begin
            n_err++; $display("FAIL busy_release: got %b expected 000", bus_if.in_ep_grant);
        end
        bus_if.pe_busy   = 1'b1;
        bus_if.in_ep_req = 3'b100;
        repeat (3) tick();
        @(negedge clk);
        n_cmp++;
        if (bus_if.in_ep_grant !== 3'b000) begin
            n_err++; $display("FAIL busy_idle_block: got %b expected 000", bus_if.in_ep_grant);
        end
        bus_if.pe_busy = 1'b0;
        tick();
        @(negedge clk);
        n_cmp++;
        if (bus_if.in_ep_grant !== 3'b100) begin
            n_err++; $display("FAIL busy_idle_grant: got %b expected 100", bus_if.in_ep_grant);
        end
        bus_if.in_ep_req = 3'b000;
        tick();
        tick();
    endtask

    task automatic test_ignore_nongranted();
        logic       exp_put;
        logic [7:0] exp_data;
        bus_if.in_ep_req = 3'b001;
        tick();
        @(negedge clk);
        n_cmp++;
        if (bus_if.in_ep_grant !== 3'b001) begin
            n_err++; $display("FAIL ign_grant: got %b expected 001", bus_if.in_ep_grant);
        end
        for (int i = 0; i < 6; i++) begin
            tick();
            exp_put  = i[0];
            exp_data = 8'(8'h10 + i);
            bus_if.in_ep_data_put  = {1'b1, 1'b0, exp_put};
            bus_if.in_ep_data      = {8'hFF, 8'h00, exp_data};
            bus_if.in_ep_data_done = 3'b100;
            @(negedge clk);
            n_cmp++;
            if ({bus_if.arb_data_put, bus_if.arb_data_done} !== {exp_put, 1'b0}) begin
                n_err++; $display("FAIL ign_put[%0d]: got put=%b done=%b expected %b/0",
                                  i, bus_if.arb_data_put, bus_if.arb_data_done, exp_put);
            end
            n_cmp++;
            if (bus_if.arb_data !== exp_data) begin
                n_err++; $display("FAIL ign_data[%0d]: got %h expected %h", i, bus_if.arb_data, exp_data);
            end
        end
        tick();
        bus_if.in_ep_req      = 3'b000;
        bus_if.in_ep_data_put = 3'b100;
        tick();
        @(negedge clk);
        n_cmp++;
        if ({bus_if.in_ep_grant, bus_if.arb_data_put, bus_if.arb_data, bus_if.arb_data_done} !== 13'h0000) begin
            n_err++; $display("FAIL ign_gap: got grant=%b put=%b data=%h done=%b expected all 0",
                              bus_if.in_ep_grant, bus_if.arb_data_put, bus_if.arb_data, bus_if.arb_data_done);
        end
        bus_if.in_ep_data_put  = '0;
        bus_if.in_ep_data      = '0;
        bus_if.in_ep_data_done = '0;
        tick();
    endtask

    task automatic test_hold();
        int         granted;
        int         pulses;
        int         exp_granted;
        int         exp_pulses;
        logic [2:0] exp_final;
`ifdef USB_IN_ARB_HOLD_TIMEOUT_EN
        exp_granted = 17;
        exp_pulses  = 1;
        exp_final   = 3'b000;
`else
        exp_granted = 41;
        exp_pulses  = 0;
        exp_final   = 3'b010;
`endif
        bus_if.in_ep_req = 3'b010;
        tick();
        @(negedge clk);
        n_cmp++;
        if (bus_if.in_ep_grant !== 3'b010) begin
            n_err++; $display("FAIL hold_grant: got %b expected 010", bus_if.in_ep_grant);
        end
        granted = 1;
        pulses  = 0;
        for (int c = 0; c < 40; c++) begin
            tick();
            @(negedge clk);
            if (bus_if.in_ep_grant === 3'b010) granted++;
            if (bus_if.arb_timeout === 1'b1) pulses++;
        end
        n_cmp++;
        if (granted !== exp_granted) begin
            n_err++; $display("FAIL hold_cycles: got %0d expected %0d", granted, exp_granted);
        end
        n_cmp++;
        if (pulses !== exp_pulses) begin
            n_err++; $display("FAIL hold_timeout_pulses: got %0d expected %0d", pulses, exp_pulses);
        end
        n_cmp++;
        if (bus_if.in_ep_grant !== exp_final) begin
            n_err++; $display("FAIL hold_final: got %b expected %b", bus_if.in_ep_grant, exp_final);
        end
        bus_if.in_ep_req = 3'b000;
        tick();
        bus_if.in_ep_req = 3'b010;
        tick();
        @(negedge clk);
        n_cmp++;
        if (bus_if.in_ep_grant !== 3'b010) begin
            n_err++; $display("FAIL hold_regrant: got %b expected 010", bus_if.in_ep_grant);
        end
        bus_if.in_ep_req = 3'b000;
        tick();
        tick();
    endtask

    task automatic test_reset_mid_grant();
        bus_if.in_ep_req = 3'b010;
        tick();
        bus_if.in_ep_data_put = 3'b010;
        bus_if.in_ep_data     = 24'h005A00;
        @(negedge clk);
        n_cmp++;
        if ({bus_if.in_ep_grant, bus_if.arb_data_put, bus_if.arb_data} !== {3'b010, 1'b1, 8'h5A}) begin
            n_err++; $display("FAIL rst_pre: got %b/%b/%h expected 010/1/5a",
                              bus_if.in_ep_grant, bus_if.arb_data_put, bus_if.arb_data);
        end
        #2;
        reset_n = 1'b0;
        #1;
        n_cmp++;
        if ({bus_if.in_ep_grant, bus_if.arb_data_put, bus_if.arb_data, bus_if.arb_data_done,
             bus_if.arb_timeout} !== 14'h0000) begin
            n_err++; $display("FAIL rst_async: got grant=%b put=%b data=%h done=%b to=%b expected all 0",
                              bus_if.in_ep_grant, bus_if.arb_data_put, bus_if.arb_data,
                              bus_if.arb_data_done, bus_if.arb_timeout);
        end
        bus_if.in_ep_req      = 3'b111;
        bus_if.in_ep_data_put = '0;
        bus_if.in_ep_data     = '0;
        @(negedge clk);
        reset_n = 1'b1;
        tick();
        @(negedge clk);
        n_cmp++;
        if (bus_if.in_ep_grant !== 3'b001) begin
            n_err++; $display("FAIL rst_ep0_first: got %b expected 001", bus_if.in_ep_grant);
        end
        bus_if.in_ep_req = '0;
        tick();
        tick();
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_single();
        test_pe_busy();
        test_ignore_nongranted();
        test_hold();
        test_reset_mid_grant();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
